// File: rtl/round_robin_distributor_if.sv
// round_robin_distributor_if: write-side and per-lane read-side signals of the round-robin distributor.
interface round_robin_distributor_if #(
  parameter int CLIENTS = 4,
  parameter int DATA_WIDTH = 8
);
  logic write;
  logic [DATA_WIDTH-1:0] wr_data;
  logic wr_full;
  logic hold;
  logic [CLIENTS-1:0] read;
  logic [CLIENTS*DATA_WIDTH-1:0] rd_data;
  logic [CLIENTS-1:0] rd_empty;
  logic dispatch;
  logic [$clog2(CLIENTS)-1:0] dispatch_lane;
  modport master (
    output write, wr_data, hold, read,
    input wr_full, rd_data, rd_empty, dispatch, dispatch_lane
  );
  modport slave (
    input write, wr_data, hold, read,
    output wr_full, rd_data, rd_empty, dispatch, dispatch_lane
  );
endinterface

// File: rtl/round_robin_distributor.sv
// round_robin_distributor: one write stream fanned out round-robin into CLIENTS FWFT lane FIFOs.
// Define RR_DIST_SKIP_FULL_EN to let dispatch skip full lanes; otherwise strict rotation.
module round_robin_distributor #(
  parameter int CLIENTS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  round_robin_distributor_if.slave bus
);
  localparam int LW = $clog2(CLIENTS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic stage_valid;
  logic [DATA_WIDTH-1:0] stage_data;
  logic [LW-1:0] ptr, lane, nxt_ptr;
  logic found, dispatch, accept;
  logic [CW-1:0] cnt [CLIENTS];
  logic [AW-1:0] wp [CLIENTS];
  logic [AW-1:0] rp [CLIENTS];
  logic [DATA_WIDTH-1:0] mem [CLIENTS][DEPTH];
  logic [CLIENTS-1:0] full, push, pop;
  genvar i;
  for (i = 0; i < CLIENTS; i++) begin : g_lane
    assign full[i] = cnt[i] == CW'(DEPTH);
    assign push[i] = dispatch && lane == LW'(i);
    assign pop[i] = bus.read[i] && cnt[i] != '0;
    assign bus.rd_empty[i] = cnt[i] == '0;
    assign bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rp[i]];
  end
  // Descending scan so the lowest offset from ptr wins without a break.
  always_comb begin
    found = 1'b0;
    lane = '0;
`ifdef RR_DIST_SKIP_FULL_EN
    for (int k = CLIENTS - 1; k >= 0; k--) begin
      if (!full[(int'(ptr) + k) % CLIENTS]) begin
        found = 1'b1;
        lane = LW'((int'(ptr) + k) % CLIENTS);
      end
    end
`else
    found = !full[ptr];
    lane = ptr;
`endif
  end
  assign dispatch = stage_valid && !bus.hold && found;
  assign bus.dispatch = dispatch;
  assign bus.dispatch_lane = dispatch ? lane : '0;
  assign bus.wr_full = stage_valid && !dispatch;
  assign accept = bus.write && !bus.wr_full;
  assign nxt_ptr = lane == LW'(CLIENTS - 1) ? '0 : lane + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_data <= '0;
      ptr <= '0;
    end else begin
      stage_valid <= accept || (stage_valid && !dispatch);
      if (accept) stage_data <= bus.wr_data;
      if (dispatch) ptr <= nxt_ptr;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < CLIENTS; l++) begin
        cnt[l] <= '0;
        wp[l] <= '0;
        rp[l] <= '0;
        for (int d = 0; d < DEPTH; d++) mem[l][d] <= '0;
      end
    end else begin
      for (int l = 0; l < CLIENTS; l++) begin
        if (push[l]) begin
          mem[l][wp[l]] <= stage_data;
          wp[l] <= wp[l] + 1'b1;
        end
        if (pop[l]) rp[l] <= rp[l] + 1'b1;
        cnt[l] <= cnt[l] + CW'(push[l]) - CW'(pop[l]);
      end
    end
  end
endmodule

// File: tb/tb_round_robin_distributor.sv
// tb_round_robin_distributor: directed and random stimulus against a queue-based reference model.
module tb_round_robin_distributor;
  localparam int C = 4;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] q [C][$];
  bit sv;
  logic [DW-1:0] sd;
  int p;
  round_robin_distributor_if #(.CLIENTS(C), .DATA_WIDTH(DW)) bus ();
  round_robin_distributor #(.CLIENTS(C), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int elig();
`ifdef RR_DIST_SKIP_FULL_EN
    for (int k = 0; k < C; k++)
      if (q[(p + k) % C].size() < DEPTH) return (p + k) % C;
    return -1;
`else
    return q[p].size() < DEPTH ? p : -1;
`endif
  endfunction
  function automatic void clear_model();
    for (int i = 0; i < C; i++) q[i].delete();
    sv = 0;
    sd = '0;
    p = 0;
  endfunction
  // Called just after a posedge: drives inputs, checks mid-cycle, then commits the model at the next edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit h, input logic [C-1:0] r);
    int l;
    bit dsp, wf;
    bus.write = w;
    bus.wr_data = d;
    bus.hold = h;
    bus.read = r;
    l = elig();
    dsp = sv && !h && l >= 0;
    wf = sv && !dsp;
    @(negedge clk);
    check("wr_full", 32'(bus.wr_full), 32'(wf));
    check("dispatch", 32'(bus.dispatch), 32'(dsp));
    check("dispatch_lane", 32'(bus.dispatch_lane), dsp ? l : 0);
    for (int i = 0; i < C; i++) begin
      check($sformatf("rd_empty[%0d]", i), 32'(bus.rd_empty[i]), 32'(q[i].size() == 0));
      if (q[i].size() > 0) check($sformatf("rd_data[%0d]", i), 32'(bus.rd_data[i*DW +: DW]), 32'(q[i][0]));
    end
    @(posedge clk);
    for (int i = 0; i < C; i++)
      if (r[i] && q[i].size() > 0) void'(q[i].pop_front());
    if (dsp) begin
      q[l].push_back(sd);
      p = (l + 1) % C;
      sv = 0;
    end
    if (w && !wf) begin
      sv = 1;
      sd = d;
    end
    #1;
  endtask
  initial begin
    bus.write = 1'b0;
    bus.wr_data = '0;
    bus.hold = 1'b0;
    bus.read = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("reset rd_empty", 32'(bus.rd_empty), 32'hF);
    check("reset wr_full", 32'(bus.wr_full), 0);
    check("reset dispatch", 32'(bus.dispatch), 0);
    check("reset dispatch_lane", 32'(bus.dispatch_lane), 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step(1, DW'(8'h10 + k), 0, '0);
    repeat (2) step(0, '0, 0, '0);
    for (int i = 0; i < C; i++) check($sformatf("head lane %0d", i), 32'(bus.rd_data[i*DW +: DW]), 32'h10 + i);
    for (int k = 0; k < 8; k++) step(1, DW'(8'h20 + k), 0, '0);
    step(1, 8'hAA, 0, '0);
    step(0, '0, 0, '0);
    check("stage held full", 32'(bus.wr_full), 1);
    step(0, '0, 0, 4'b0100);
    repeat (2) step(0, '0, 0, '0);
    repeat (5) step(0, '0, 1, '0);
    repeat (6) step(0, '0, 0, 4'hF);
    step(1, 8'h5A, 0, '0);
    repeat (5) step(0, '0, 1, '0);
    repeat (3) step(0, '0, 0, '0);
    repeat (8) step(0, '0, 0, 4'hF);
    step(0, '0, 0, 4'b0010);
    check("empty read stays empty", 32'(bus.rd_empty[1]), 1);
    for (int k = 0; k < 3; k++) step(1, DW'(k + 1), 0, '0);
    rst = 1'b1;
    #1;
    check("midreset rd_empty", 32'(bus.rd_empty), 32'hF);
    check("midreset wr_full", 32'(bus.wr_full), 0);
    check("midreset dispatch", 32'(bus.dispatch), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    step(1, 8'h55, 0, '0);
    check("post reset lane", 32'(bus.dispatch_lane), 0);
    repeat (2) step(0, '0, 0, '0);
    check("post reset lane0 head", 32'(bus.rd_data[0 +: DW]), 32'h55);
    for (int n = 0; n < 500; n++) begin
      logic [C-1:0] r;
      for (int i = 0; i < C; i++) r[i] = $urandom_range(0, 3) == 0;
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 7) == 0, r);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/round_robin_distributor.md
# round_robin_distributor

Fan-out counterpart of the round-robin merge path. It accepts one 8-bit write stream and distributes each word to one of CLIENTS per-lane output FIFOs in round-robin order. Lanes that are full are skipped. Each lane presents a FIFO-style read port to its own consumer. The block sits between a single producer FIFO and CLIENTS independent downstream consumers.

## Interface
- CLIENTS, 4: number of output lanes; range 2..8.
- DATA_WIDTH, 8: word width.
- DEPTH, 4: per-lane FIFO depth; power of two, at least 2.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- write  in  1  input write strobe; accepted only when wr_full is low.
- wr_data  in  DATA_WIDTH  input word.
- wr_full  out  1  input cannot accept this cycle.
- hold  in  1  suspends dispatch, level-sensitive.
- read  in  CLIENTS  per-lane pop strobe.
- rd_data  out  CLIENTS*DATA_WIDTH  per-lane head word; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- rd_empty  out  CLIENTS  per-lane empty flag.
- dispatch  out  1  a word moves from the stage into a lane this cycle.
- dispatch_lane  out  $clog2(CLIENTS)  lane receiving the word; 0 when dispatch is low.

## Operation
- Input stage: a single-entry register (stage_valid, stage_data).
  - Loads when write && !wr_full.
  - Clears on dispatch unless it reloads in the same cycle.
- wr_full = stage_valid && !dispatch, combinational. Back-to-back writes sustain 1 word/cycle while lanes have space.
- Lane full flag = registered count == DEPTH. A read in the same cycle does not free the slot for a dispatch that cycle.
- Dispatch condition: stage_valid && !hold && an eligible lane exists.
- Eligible lane: the first not-full lane searched from ptr upward, wrapping mod CLIENTS.
- On dispatch, ptr <= (dispatch_lane + 1) mod CLIENTS. With no dispatch, ptr holds.
- Lane FIFOs are first-word-fall-through.
  - rd_data shows the head whenever rd_empty is low.
  - read pops on posedge.
  - read while empty is ignored and count stays 0.
  - rd_data is don't-care while empty.
- A simultaneous push and pop on a non-empty lane leaves count unchanged and keeps data order.
- Pointer arithmetic: per-lane read/write pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits.
- Reset values:
  - Stage and control: stage_valid 0, ptr 0, wr_full 0.
  - Lanes: all counts and pointers 0, rd_empty all 1.
  - Status: dispatch 0, dispatch_lane 0, storage cleared to 0.
- Reset asserted mid-operation:
  - All state clears immediately.
  - Words in the stage or in lanes are discarded.
  - No dispatch is asserted while rst is high.

## Timing
- Write accepted at edge N: the stage is valid in cycle N+1. If dispatchable, dispatch is high in N+1 and lane rd_empty falls after edge N+1, so data is visible in cycle N+2.
- Write-to-lane-visible latency is 2 cycles minimum. hold or all-lanes-full add one cycle per stalled cycle.
- When hold is asserted, dispatch goes low the same cycle and wr_full equals stage_valid. Release resumes at the stored ptr.
- dispatch and dispatch_lane are combinational from registered state plus hold, and are valid before the edge that commits them.

## Configuration
- RR_DIST_SKIP_FULL_EN:
  - Defined: eligible-lane search skips full lanes, as described above.
  - Undefined: strict rotation. Only lane ptr is eligible, and dispatch waits while lane ptr is full even when other lanes have space. ptr still advances by exactly one per dispatch.

## Test plan
- Reset, then write 0x10..0x17 on consecutive cycles, no reads, DEPTH 4. Required:
  - Lanes 0..3 receive 0x10/0x14, 0x11/0x15, 0x12/0x16, 0x13/0x17 in order.
  - wr_full stays low throughout.
  - The lane heads read 0x10, 0x11, 0x12, 0x13.
- Fill lane 1 to DEPTH, then write 4 words with ptr=1. Required:
  - With RR_DIST_SKIP_FULL_EN: words go to lanes 2, 3, 0, 2.
  - Without the macro: wr_full stays high and dispatch stays low until read[1] is pulsed; the first word then goes to lane 1 one cycle after the pop.
- Fill all lanes to full, then write 0xAA. Required:
  - The stage holds 0xAA and wr_full=1.
  - Pulse read[2]: 0xAA dispatches to lane 2 in the following cycle.
- Assert hold for 5 cycles with the stage valid. Required:
  - dispatch=0 and wr_full=1 throughout.
  - On release, dispatch goes to the lane at ptr.
- Read a lane while it is empty, and push+pop on a lane with count 2. Required:
  - The empty read leaves count 0 and rd_empty 1.
  - The push+pop keeps count 2 and preserves FIFO order.
- Assert rst mid-stream with 3 words buffered. Required:
  - Outputs immediately become rd_empty=all 1, wr_full=0, dispatch=0.
  - After release, the first write goes to lane 0.
